// File: rtl/rv_mul.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, sharing the MDU start/stall/kill/keep handshake.
// Optional macro RV_MUL_EARLY_TERM_EN: leave COMP as soon as the remaining multiplier bits are all zero.

package rv_pkg;
  localparam int XLEN = 32;
endpackage

package rv_mdu_pkg;
  localparam int MDU_OP_W = 3;
  localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
  localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;
endpackage

module rv_mul
  import rv_pkg::*;
  import rv_mdu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1  // 1, 2 or 4; must divide XLEN
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                mul_start_i,
  input  logic [XLEN-1:0]     port_a_i,
  input  logic [XLEN-1:0]     port_b_i,
  input  logic [MDU_OP_W-1:0] mdu_op_i,
  input  logic                zero_i,
  input  logic                kill_i,
  input  logic                keep_i,
  output logic [XLEN-1:0]     mul_result_o,
  output logic                mul_stall_req_o
);

  localparam int ITERS  = XLEN / BITS_PER_CYCLE;
  localparam int ITER_W = $clog2(ITERS) + 1;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_COMP,
    MUL_SIGN_CHANGE,
    MUL_FINISH
  } mul_state_e;

  mul_state_e state_ff, state_nx;

  logic [2*XLEN-1:0] mcand_ff;
  logic [XLEN-1:0]   mplier_ff;
  logic [2*XLEN-1:0] acc_ff;
  logic              sign_inv_ff;
  logic              hi_sel_ff;
  logic [ITER_W-1:0] iter_ff;

  logic              a_signed, b_signed;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc_step, mcand_step;
  logic [XLEN-1:0]   mplier_step;
  logic              comp_last;
  logic              done;

  // Operand decode, only sampled in IDLE.
  assign a_signed = (mdu_op_i == MDU_MULH) || (mdu_op_i == MDU_MULHSU);
  assign b_signed = (mdu_op_i == MDU_MULH);
  assign sign_a   = a_signed & port_a_i[XLEN-1];
  assign sign_b   = b_signed & port_b_i[XLEN-1];
  assign mag_a    = sign_a ? -port_a_i : port_a_i;
  assign mag_b    = sign_b ? -port_b_i : port_b_i;

  // NOTE: always_comb gives every variable a default before any branch so no latch is inferred.
  always_comb begin
    acc_step    = acc_ff;
    mcand_step  = mcand_ff;
    mplier_step = mplier_ff;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_step[0]) acc_step = acc_step + mcand_step;
      mcand_step  = mcand_step << 1;
      mplier_step = mplier_step >> 1;
    end
  end

`ifdef RV_MUL_EARLY_TERM_EN
  assign comp_last = (iter_ff == ITER_W'(1)) || (mplier_step == '0);
`else
  assign comp_last = (iter_ff == ITER_W'(1));
`endif

  always_comb begin
    state_nx = state_ff;
    unique case (state_ff)
      MUL_IDLE:        if (mul_start_i) state_nx = zero_i ? MUL_FINISH : MUL_COMP;
      MUL_COMP:        if (comp_last) state_nx = sign_inv_ff ? MUL_SIGN_CHANGE : MUL_FINISH;
      MUL_SIGN_CHANGE: state_nx = MUL_FINISH;
      MUL_FINISH:      if (!keep_i) state_nx = MUL_IDLE;
      default:         state_nx = MUL_IDLE;
    endcase
    if (kill_i) state_nx = MUL_IDLE;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_ff <= MUL_IDLE;
    else          state_ff <= state_nx;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mcand_ff    <= '0;
      mplier_ff   <= '0;
      acc_ff      <= '0;
      sign_inv_ff <= 1'b0;
      hi_sel_ff   <= 1'b0;
      iter_ff     <= '0;
    end else begin
      unique case (state_ff)
        MUL_IDLE: begin
          if (mul_start_i && !kill_i) begin
            mplier_ff   <= mag_a;
            mcand_ff    <= {{XLEN{1'b0}}, mag_b};
            acc_ff      <= '0;
            iter_ff     <= ITER_W'(ITERS);
            // sign_a/sign_b are already zero for unsigned operands, so one xor covers all four ops.
            sign_inv_ff <= sign_a ^ sign_b;
            hi_sel_ff   <= (mdu_op_i != MDU_MUL);
          end
        end
        MUL_COMP: begin
          acc_ff    <= acc_step;
          mcand_ff  <= mcand_step;
          mplier_ff <= mplier_step;
          iter_ff   <= iter_ff - ITER_W'(1);
        end
        MUL_SIGN_CHANGE: acc_ff <= -acc_ff;
        default: ;
      endcase
    end
  end

  assign done            = (state_ff == MUL_FINISH);
  assign mul_stall_req_o = mul_start_i && !done;
  assign mul_result_o    = hi_sel_ff ? acc_ff[2*XLEN-1:XLEN] : acc_ff[XLEN-1:0];

endmodule
